imm_extend_pipe: RTL and testbench



---
 rtl/imm_pkg.sv | 46 ++++
 rtl/imm_extend_pipe_skid_buf.sv | 77 +++++++
 rtl/imm_extend_pipe.sv | 54 +++++
 tb/tb_imm_extend_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-extension definitions: mode encodings, buffer states and a
// width-generic reference extender usable by both the pipe and decode-side checkers.
package imm_pkg;

   localparam int unsigned IMM_MAX_W = 64;

   localparam logic [1:0] MODE_SEXT = 2'b00;
   localparam logic [1:0] MODE_ZEXT = 2'b01;
   localparam logic [1:0] MODE_LUI  = 2'b10;
   localparam logic [1:0] MODE_BOFF = 2'b11;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b01,
      BUF_TWO   = 2'b10
   } buf_state_e;

   // Widths are arguments rather than parameters so one function serves every
   // instance; callers truncate the IMM_MAX_W-bit result to their own out_w.
   function automatic logic [IMM_MAX_W-1:0] imm_extend(
      input logic [IMM_MAX_W-1:0] imm,
      input logic [1:0]           mode,
      input int unsigned          in_w,
      input int unsigned          out_w
   );
      logic [IMM_MAX_W-1:0] one;
      logic [IMM_MAX_W-1:0] in_mask;
      logic [IMM_MAX_W-1:0] out_mask;
      logic [IMM_MAX_W-1:0] raw;
      logic [IMM_MAX_W-1:0] sext;
      logic [IMM_MAX_W-1:0] res;
      one      = {{(IMM_MAX_W-1){1'b0}}, 1'b1};
      in_mask  = (one << in_w) - one;
      out_mask = (out_w >= IMM_MAX_W) ? '1 : ((one << out_w) - one);
      raw      = imm & in_mask;
      sext     = ((raw & (one << (in_w - 1))) != '0) ? (raw | ~in_mask) : raw;
      case (mode)
         MODE_SEXT: res = sext;
         MODE_ZEXT: res = raw;
         MODE_LUI:  res = raw << (out_w - in_w);
         default:   res = sext << 2;
      endcase
      return res & out_mask;
   endfunction

endpackage

// File: rtl/imm_extend_pipe_skid_buf.sv
// Two-entry valid/ready buffer (main + skid); 1-cycle latency when empty.
// Back-pressure: in_rdy_o is registered-only (no path from out_rdy_i); drops to 0 when both entries are full.
module skid_buf
   import imm_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld_i,
   output logic         in_rdy_o,
   input  logic [W-1:0] in_dat_i,
   output logic         out_vld_o,
   input  logic         out_rdy_i,
   output logic [W-1:0] out_dat_o
);

   buf_state_e   state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         rdy_q;
   logic         in_xfer;
   logic         out_xfer;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_d    = skid_q;
      in_rdy_o  = rst_n && rdy_q && (state_q != BUF_TWO);
      out_vld_o = (state_q != BUF_EMPTY);
      out_dat_o = main_q;
      in_xfer   = in_vld_i && in_rdy_o;
      out_xfer  = out_vld_o && out_rdy_i;

      case (state_q)
         BUF_EMPTY: begin
            if (in_xfer) begin
               main_d  = in_dat_i;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_dat_i;
            end else if (in_xfer) begin
               skid_d  = in_dat_i;
               state_d = BUF_TWO;
            end else if (out_xfer) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            // in_rdy_o is low here, so only the drain path can fire
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (SEXT/ZEXT/LUI/BOFF) feeding a 2-entry skid buffer; 1-cycle latency.
// Back-pressure: out_ready stalls hold outputs stable; in_ready falls only once both entries are full.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg
);

   localparam int unsigned PAY_W = OUT_W + TAG_W;

   if (IN_W < 2 || OUT_W < IN_W + 2 || OUT_W > IMM_MAX_W || IN_W >= IMM_MAX_W) begin : g_bad_widths
      $error("imm_extend_pipe: need 2 <= IN_W, IN_W+2 <= OUT_W <= %0d", IMM_MAX_W);
   end

   logic [OUT_W-1:0] ext_dat;
   logic [PAY_W-1:0] pay_in;
   logic [PAY_W-1:0] pay_out;

   assign ext_dat = OUT_W'(imm_extend(IMM_MAX_W'(in_imm), in_mode, IN_W, OUT_W));
   assign pay_in  = {in_tag, ext_dat};

   skid_buf #(
      .W (PAY_W)
   ) u_skid_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld_i  (in_valid),
      .in_rdy_o  (in_ready),
      .in_dat_i  (pay_in),
      .out_vld_o (out_valid),
      .out_rdy_i (out_ready),
      .out_dat_o (pay_out)
   );

   assign out_data = pay_out[OUT_W-1:0];
   assign out_tag  = pay_out[PAY_W-1 -: TAG_W];
   assign out_neg  = out_data[OUT_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and random checks of imm_extend_pipe at 16->32 and 8->16 widths.
module tb_imm_extend_pipe;
   import imm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_neg;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] out_data;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_neg;
   logic [7:0]  s_in_imm;
   logic [1:0]  s_in_mode;
   logic [4:0]  s_in_tag, s_out_tag;
   logic [15:0] s_out_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] dat;
      logic [4:0]  tag;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_neg(out_neg)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm), .in_mode(s_in_mode), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_tag(s_out_tag), .out_neg(s_out_neg)
   );

   function automatic logic [31:0] ref32(input logic [15:0] imm, input logic [1:0] mode);
      case (mode)
         2'b00:   return {{16{imm[15]}}, imm};
         2'b01:   return {16'h0000, imm};
         2'b10:   return {imm, 16'h0000};
         default: return {{14{imm[15]}}, imm, 2'b00};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_input();
      in_imm  = 16'($urandom);
      in_mode = 2'($urandom_range(0, 3));
      in_tag  = 5'($urandom);
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: unexpected output data=%h tag=%h, scoreboard empty", name, out_data, out_tag);
      end else begin
         e = sb.pop_front();
         if (out_data !== e.dat || out_tag !== e.tag || out_neg !== e.dat[31]) begin
            n_fail++;
            $display("FAIL %s: got data=%h tag=%h neg=%b expected data=%h tag=%h neg=%b",
                     name, out_data, out_tag, out_neg, e.dat, e.tag, e.dat[31]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_imm = '0; in_mode = '0; in_tag = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_imm = '0; s_in_mode = '0; s_in_tag = '0;
      step(); step();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || out_neg !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%h t=%h n=%b expected all zero", out_valid, out_data, out_tag, out_neg);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready_high: got %b/%b expected 1/1", in_ready, s_in_ready);
      end
   endtask

   task automatic test_modes();
      logic [31:0] exp_d [4];
      logic        exp_n [4];
      exp_d[0] = 32'hFFFF8004; exp_n[0] = 1'b1;
      exp_d[1] = 32'h00008004; exp_n[1] = 1'b0;
      exp_d[2] = 32'h80040000; exp_n[2] = 1'b1;
      exp_d[3] = 32'hFFFE0010; exp_n[3] = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_imm = 16'h8004; in_mode = 2'(i); in_tag = 5'(i + 4);
         step();
         in_valid = 1'b0;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_neg !== exp_n[i] || out_tag !== 5'(i + 4)) begin
            n_fail++;
            $display("FAIL mode_%0d: got v=%b d=%h n=%b t=%h expected v=1 d=%h n=%b t=%h",
                     i, out_valid, out_data, out_neg, out_tag, exp_d[i], exp_n[i], 5'(i + 4));
         end
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_%0d_single: out_valid got %b expected 0", i, out_valid);
         end
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      in_valid = 1'b1; in_imm = 16'h0011; in_mode = MODE_ZEXT; in_tag = 5'd1;
      step();
      in_imm = 16'h0022; in_tag = 5'd2;
      step();
      in_imm = 16'h0033; in_tag = 5'd3;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11 || out_tag !== 5'd1) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got rdy=%b v=%b d=%h t=%h expected rdy=0 v=1 d=00000011 t=01",
                     k, in_ready, out_valid, out_data, out_tag);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_data !== 32'h22 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_drain_2: got v=%b t=%h d=%h rdy=%b expected v=1 t=02 d=00000022 rdy=1",
                  out_valid, out_tag, out_data, in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'h33) begin
         n_fail++;
         $display("FAIL stall_drain_3: got v=%b t=%h d=%h expected v=1 t=03 d=00000033", out_valid, out_tag, out_data);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_empty: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int gaps = 0;
      int n_out = 0;
      sb.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 105; c++) begin
         if (out_valid) begin
            pop_check("stream_data");
            n_out++;
         end else if (c >= 1 && c <= 100) begin
            gaps++;
         end
         if (c < 100) begin
            in_valid = 1'b1;
            rand_input();
            if (in_ready) sb.push_back({ref32(in_imm, in_mode), in_tag});
            else gaps++;
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      n_checks++;
      if (n_out != 100 || gaps != 0) begin
         n_fail++;
         $display("FAIL stream_rate: got %0d outputs with %0d gaps expected 100 outputs 0 gaps", n_out, gaps);
      end
   endtask

   task automatic test_random_backpressure();
      logic pend = 1'b0;
      logic last_stall = 1'b0;
      exp_t last = '0;
      sb.delete();
      for (int c = 0; c < 400; c++) begin
         if (last_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== last.dat || out_tag !== last.tag) begin
               n_fail++;
               $display("FAIL rand_stable: got v=%b d=%h t=%h expected v=1 d=%h t=%h",
                        out_valid, out_data, out_tag, last.dat, last.tag);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) pop_check("rand_data");
         last_stall = out_valid && !out_ready;
         last = {out_data, out_tag};
         if (!pend) begin
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid) rand_input();
         end
         if (in_valid && in_ready) begin
            sb.push_back({ref32(in_imm, in_mode), in_tag});
            pend = 1'b0;
         end else begin
            pend = in_valid;
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) pop_check("rand_drain");
         step();
      end
      n_checks++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rand_complete: got %0d undelivered, out_valid=%b expected 0 and 0", sb.size(), out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_imm = 16'h1234; in_mode = MODE_LUI; in_tag = 5'h1A;
      step();
      in_tag = 5'h1B;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_fill: got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_clear: got v=%b d=%h t=%h rdy=%b expected 0 0 0 0", out_valid, out_data, out_tag, in_ready);
      end
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready: in_ready got %b expected 1", in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stale_%0d: out_valid got %b expected 0", k, out_valid);
         end
         step();
      end
      in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = MODE_BOFF; in_tag = 5'h05;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0001FFFC || out_tag !== 5'h05 || out_neg !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_after: got v=%b d=%h t=%h n=%b expected v=1 d=0001fffc t=05 n=0",
                  out_valid, out_data, out_tag, out_neg);
      end
      step();
   endtask

   task automatic test_param_8_16();
      logic [7:0]  imm_v [4];
      logic [1:0]  mode_v [4];
      logic [15:0] exp_d [4];
      imm_v[0] = 8'h80; mode_v[0] = MODE_BOFF; exp_d[0] = 16'hFE00;
      imm_v[1] = 8'h7F; mode_v[1] = MODE_SEXT; exp_d[1] = 16'h007F;
      imm_v[2] = 8'h80; mode_v[2] = MODE_LUI;  exp_d[2] = 16'h8000;
      imm_v[3] = 8'h80; mode_v[3] = MODE_ZEXT; exp_d[3] = 16'h0080;
      s_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_in_valid = 1'b1; s_in_imm = imm_v[i]; s_in_mode = mode_v[i]; s_in_tag = 5'(i + 9);
         step();
         s_in_valid = 1'b0;
         n_checks++;
         if (s_out_valid !== 1'b1 || s_out_data !== exp_d[i] || s_out_neg !== exp_d[i][15] || s_out_tag !== 5'(i + 9)) begin
            n_fail++;
            $display("FAIL param8_%0d: got v=%b d=%h n=%b t=%h expected v=1 d=%h n=%b t=%h",
                     i, s_out_valid, s_out_data, s_out_neg, s_out_tag, exp_d[i], exp_d[i][15], 5'(i + 9));
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_stall();
      test_back_to_back();
      test_random_backpressure();
      test_reset_mid();
      test_param_8_16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
